// File: rtl/delay_timer_arb.sv
`default_nettype none
// ============================================================================
// Module   : delay_timer_arb
// Brief    : Round-robin sharing of one adjustable delay counter among NREQ
//            requesters; programs the counter, waits for its strobe, pulses done.
// Revision : 1.0
// ============================================================================
module delay_timer_arb #(
    parameter int NREQ = 4,
    parameter int dw   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*dw-1:0]       req_delay,
    input  logic                     abort,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     tmr_load,
    output logic [dw-1:0]            tmr_limit,
    output logic                     tmr_en,
    input  logic                     tmr_strb
);

    localparam int GW = $clog2(NREQ);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_CLR  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [dw-1:0]   delay_q, delay_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic            load_q, load_d;
    logic [dw-1:0]   limit_q, limit_d;
    logic            en_q, en_d;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic [dw-1:0]   w_delay_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_delay_arr[g] = req_delay[g*dw +: dw];
    end

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % 32'(NREQ);
        return sum[GW-1:0];
    endfunction

    // First set request strictly after the last grant, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[wrap_idx(rr_q, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(rr_q, k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            rr_q    <= GW'(NREQ - 1);
            grant_q <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            delay_q <= delay_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        delay_d = delay_q;
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    rr_d    = w_pick;
                    grant_d = w_pick;
                    delay_d = w_delay_arr[w_pick];
                    state_d = (w_delay_arr[w_pick] == '0) ? c_DONE : c_LOAD;
                end
            end
            c_LOAD: state_d = abort ? c_CLR : c_RUN;
            c_RUN: begin
                // Abort takes priority over a strobe arriving in the same cycle.
                if (abort) begin
                    state_d = c_CLR;
                end else if (tmr_strb) begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            c_CLR:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port is registered.
    always_comb begin
        busy_d  = (state_d != c_IDLE);
        load_d  = (state_d == c_LOAD) || (state_d == c_CLR);
        limit_d = (state_d == c_LOAD) ? delay_d : '0;
        en_d    = (state_d == c_RUN);
        done_d  = '0;
        if (state_d == c_DONE) begin
            done_d[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q  <= '0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            limit_q <= '0;
            en_q    <= 1'b0;
        end else begin
            done_q  <= done_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            limit_q <= limit_d;
            en_q    <= en_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign tmr_load  = load_q;
    assign tmr_limit = limit_q;
    assign tmr_en    = en_q;

endmodule
`default_nettype wire
